// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer:
// state encoding and the default buffer address width.
package la_pkg;

    localparam int LA_ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } la_state_t;

endpackage

// File: rtl/la_wr_addr_gen.sv
// Circular sample-RAM write address generator: a wrapping counter with clear,
// plus registered write enable/address that trail each increment by one cycle.
module la_wr_addr_gen #(
    parameter int ADDR_W = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    input  logic              inc,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_en <= inc;
            if (clr) begin
                addr <= '0;
            end else if (inc) begin
                wr_addr <= addr;
                addr    <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample buffer (IDLE/PRE/WAIT/POST/DONE).
// Optional forced trigger after TIMEOUT strobes: define LA_TRIG_TIMEOUT_EN.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W
`ifdef LA_TRIG_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              smp_en,
    input  logic              trig_hit,
    input  logic [ADDR_W-1:0] pre_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_base,
    output logic              finished,
    input  logic              rd_done,
    output logic              busy,
    output logic              timed_out,
    output la_state_t         dbg_state
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    la_state_t         state, state_nx;
    logic [ADDR_W-1:0] pre_q, pre_nx;
    logic [ADDR_W:0]   cnt, cnt_nx, cnt_inc, post_lim;
    logic [ADDR_W-1:0] rd_base_q, rd_base_nx;
    logic [ADDR_W-1:0] addr;
    logic              clr, inc, to_hit;

    assign cnt_inc  = cnt + CNT_ONE;
    assign post_lim = DEPTH - {1'b0, pre_q};

    la_wr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (clr),
        .inc     (inc),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .addr    (addr)
    );

`ifdef LA_TRIG_TIMEOUT_EN
    logic [23:0] to_cnt;
    logic        to_q;

    assign to_hit = (state == ST_WAIT) && smp_en && ((to_cnt + 24'd1) == TIMEOUT);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if (state != ST_WAIT || abort)
                to_cnt <= '0;
            else if (smp_en)
                to_cnt <= to_cnt + 24'd1;
            if (state == ST_IDLE && start && !abort)
                to_q <= 1'b0;
            else if (to_hit && !abort)
                to_q <= 1'b1;
        end
    end

    assign timed_out = to_q;
`else
    assign to_hit    = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            pre_q     <= '0;
            cnt       <= '0;
            rd_base_q <= '0;
        end else begin
            state     <= state_nx;
            pre_q     <= pre_nx;
            cnt       <= cnt_nx;
            rd_base_q <= rd_base_nx;
        end
    end

    // Handshake: start is a one-cycle arm pulse accepted only in IDLE; finished is a
    // level that holds until rd_done is seen. abort wins over rd_done, rd_done over start.
    always_comb begin
        state_nx   = state;
        pre_nx     = pre_q;
        cnt_nx     = cnt;
        rd_base_nx = rd_base_q;
        clr        = 1'b0;
        inc        = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pre_nx   = pre_len;
                        cnt_nx   = '0;
                        clr      = 1'b1;
                        state_nx = (pre_len == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (smp_en) begin
                        inc    = 1'b1;
                        cnt_nx = cnt_inc;
                        if (cnt_inc == {1'b0, pre_q})
                            state_nx = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (smp_en) begin
                        inc = 1'b1;
                        if (trig_hit || to_hit) begin
                            // Oldest kept sample sits pre_q slots behind the trigger.
                            rd_base_nx = addr - pre_q;
                            cnt_nx     = CNT_ONE;
                            state_nx   = (post_lim == CNT_ONE) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (smp_en) begin
                        inc    = 1'b1;
                        cnt_nx = cnt_inc;
                        if (cnt_inc == post_lim)
                            state_nx = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rd_done)
                        state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    assign finished  = (state == ST_DONE);
    assign rd_base   = rd_base_q;
    assign dbg_state = state;

endmodule
